// File: rtl/ring_buffer_reader.sv
`default_nettype none
// ============================================================================
// Module     : ring_buffer_reader
// Description: Pop-side engine for a transactional ring buffer in shared
//              single-port memory (committed/speculative read pointers).
// Revision   : 1.0 - initial release
// ============================================================================
module ring_buffer_reader #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W:0]   wr_ptr,
    input  logic              pop_request,
    output logic              pop_done,
    output logic [DATA_W-1:0] pop_data,
    input  logic              open,
    input  logic              commit,
    input  logic              rollback,
    output logic              mem_rd_request,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_rd_ready,
    input  logic [DATA_W-1:0] mem_rd_data,
    output logic [ADDR_W:0]   rd_ptr,
    output logic [ADDR_W:0]   used,
    output logic              empty,
    output logic              busy,
    output logic              underflow
);

    localparam logic [1:0] c_idle = 2'd0;
    localparam logic [1:0] c_read = 2'd1;
    localparam logic [1:0] c_done = 2'd2;

    logic [1:0]        r_state;
    logic [ADDR_W:0]   r_rc;
    logic [ADDR_W:0]   r_rs;
    logic              r_txn_open;
    logic              r_pend_open;
    logic              r_pend_commit;
    logic              r_pend_rollback;
    logic              r_underflow;
    logic [DATA_W-1:0] r_pop_data;

    logic              w_idle;
    logic              w_do_rollback;
    logic              w_do_commit;
    logic              w_do_open;
    logic [ADDR_W:0]   w_rc_ctrl;
    logic [ADDR_W:0]   w_rs_ctrl;
    logic              w_txn_ctrl;
    logic              w_empty_ctrl;
    logic [ADDR_W:0]   w_rs_inc;

    assign w_idle = (r_state == c_idle);

    // In IDLE, strobes latched while busy are merged with this cycle's strobes.
    assign w_do_rollback = r_pend_rollback | rollback;
    assign w_do_commit   = r_pend_commit   | commit;
    assign w_do_open     = r_pend_open     | open;

    always_comb begin
        w_rc_ctrl  = r_rc;
        w_rs_ctrl  = r_rs;
        w_txn_ctrl = r_txn_open;
        if (w_do_rollback) begin
            w_rs_ctrl  = r_rc;
            w_txn_ctrl = 1'b0;
        end else if (w_do_commit) begin
            if (r_txn_open) begin
                w_rc_ctrl  = r_rs;
                w_txn_ctrl = 1'b0;
            end
        end else if (w_do_open) begin
            w_rs_ctrl  = r_rc;
            w_txn_ctrl = 1'b1;
        end
    end

    // Pop decision sees the pointer after this cycle's control updates.
    assign w_empty_ctrl = (wr_ptr == w_rs_ctrl);
    assign w_rs_inc     = r_rs + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state         <= c_idle;
            r_rc            <= '0;
            r_rs            <= '0;
            r_txn_open      <= 1'b0;
            r_pend_open     <= 1'b0;
            r_pend_commit   <= 1'b0;
            r_pend_rollback <= 1'b0;
            r_underflow     <= 1'b0;
            r_pop_data      <= '0;
        end else begin
            r_underflow <= w_idle & pop_request & w_empty_ctrl;
            case (r_state)
                c_idle: begin
                    r_rc            <= w_rc_ctrl;
                    r_rs            <= w_rs_ctrl;
                    r_txn_open      <= w_txn_ctrl;
                    r_pend_open     <= 1'b0;
                    r_pend_commit   <= 1'b0;
                    r_pend_rollback <= 1'b0;
                    if (pop_request && !w_empty_ctrl) begin
                        r_state <= c_read;
                    end
                end
                c_read: begin
                    r_pend_open     <= r_pend_open     | open;
                    r_pend_commit   <= r_pend_commit   | commit;
                    r_pend_rollback <= r_pend_rollback | rollback;
                    if (mem_rd_ready) begin
                        r_pop_data <= mem_rd_data;
                        r_rs       <= w_rs_inc;
                        if (!r_txn_open) begin
                            r_rc <= w_rs_inc;
                        end
                        r_state <= c_done;
                    end
                end
                c_done: begin
                    r_pend_open     <= r_pend_open     | open;
                    r_pend_commit   <= r_pend_commit   | commit;
                    r_pend_rollback <= r_pend_rollback | rollback;
                    r_state         <= c_idle;
                end
                default: begin
                    r_state <= c_idle;
                end
            endcase
        end
    end

    assign pop_done       = (r_state == c_done);
    assign pop_data       = r_pop_data;
    assign mem_rd_request = (r_state == c_read);
    assign mem_addr       = r_rs[ADDR_W-1:0];
    assign rd_ptr         = r_rc;
    assign used           = wr_ptr - r_rs;
    assign empty          = (used == '0);
    assign busy           = !w_idle;
    assign underflow      = r_underflow;

endmodule
`default_nettype wire

// File: doc/ring_buffer_reader.md
Name: ring_buffer_reader

Overview:
- Pop-side (reader) engine for one transactional ring buffer held in shared single-port memory.
- Counterpart of the push/writer path: turns single-cycle pop strobes into memory read requests and returns the data word.
- Tracks a committed and a speculative read pointer, so a frame can be consumed under open/commit/rollback.
- Publishes the committed read pointer back to the writer side so it can compute free space.

Parameters:
- ADDR_W, 8, ring address width; ring depth = 2^ADDR_W words.
- DATA_W, 16, data word width.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- wr_ptr  in  ADDR_W+1  committed write pointer from writer, extra MSB is the wrap bit.
- pop_request  in  1  single-cycle pop strobe.
- pop_done  out  1  one-cycle pulse: pop_data valid.
- pop_data  out  DATA_W  popped word, held until the next pop_done.
- open  in  1  start read transaction.
- commit  in  1  commit transaction.
- rollback  in  1  discard transaction.
- mem_rd_request  out  1  memory read request, held until mem_rd_ready.
- mem_addr  out  ADDR_W  read address.
- mem_rd_ready  in  1  memory read data valid this cycle.
- mem_rd_data  in  DATA_W  memory read data.
- rd_ptr  out  ADDR_W+1  committed read pointer to writer.
- used  out  ADDR_W+1  words available = wr_ptr − spec pointer, modulo 2^(ADDR_W+1).
- empty  out  1  used == 0.
- busy  out  1  FSM not in IDLE.
- underflow  out  1  one-cycle pulse: pop_request while empty.

Behaviour:
- Pointers: rc (committed) and rs (speculative), both ADDR_W+1 bits, wrapping modulo 2^(ADDR_W+1).
  - mem_addr = rs[ADDR_W-1:0].
  - rd_ptr = rc.
- Reset: rc = rs = 0, FSM = IDLE, txn_open = 0, all pending flags 0.
  - Outputs after reset: pop_done, mem_rd_request, underflow, busy = 0; pop_data = 0.
  - Reset is synchronous and wins over every other input, including mid-read; the memory request drops at that edge.
- FSM states: IDLE, READ, DONE.
- IDLE:
  - pop_request & !empty -> READ.
  - pop_request & empty -> underflow = 1 next cycle, stay in IDLE.
  - pop_request in READ/DONE is ignored; no underflow pulse.
- READ: mem_rd_request = 1 and mem_addr stable until mem_rd_ready. On mem_rd_ready:
  - pop_data <= mem_rd_data;
  - rs <= rs + 1;
  - if !txn_open, rc <= rs + 1 (auto-commit);
  - go to DONE.
- DONE: pop_done = 1 for exactly one cycle, then IDLE.
- Minimum pop latency: pop_request at cycle n -> mem_rd_request at n+1; with mem_rd_ready at n+1, pop_done at n+2.
- Transaction controls (single-cycle strobes):
  - open: txn_open <= 1, rs <= rc. A second open while already open behaves as rollback then open.
  - commit: rc <= rs, txn_open <= 0. Commit without an open transaction is a no-op.
  - rollback: rs <= rc, txn_open <= 0.
  - Priority within one cycle: rollback > commit > open.
- Control strobes seen while busy are latched in pend_open/pend_commit/pend_rollback and applied in the first IDLE cycle, before pop_request is evaluated. Same priority applies; pending flags are cleared when applied.
- empty/used are computed from rs (speculative), so a rolled-back frame becomes available again.
- wr_ptr is trusted to never exceed rc + 2^ADDR_W; no overflow check in this block.

Test Plan:
- Reset, wr_ptr=3, memory holds 0x1111/0x2222/0x3333 at 0..2; pop three times -> pop_data 0x1111, 0x2222, 0x3333; rd_ptr=3, empty=1.
- wr_ptr=3, open, pop twice, rollback -> rs=rd_ptr=0, used=3; pop again -> 0x1111.
- open, pop twice, commit -> rd_ptr=2, used=1; a further rollback leaves rd_ptr=2.
- empty ring (wr_ptr=0), pop_request -> underflow pulse 1 cycle, no mem_rd_request, pop_done stays 0.
- Wrap: ADDR_W=8, rc=rs=0x0FF, wr_ptr=0x101; two pops -> mem_addr 0xFF then 0x00; rd_ptr=0x101.
- rollback strobed during READ with mem_rd_ready delayed 3 cycles -> pop completes with pop_done, then rs=rc in the first IDLE cycle. rst asserted in READ -> mem_rd_request=0 and all pointers 0 after that edge.
